// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM posted-write path.
package vram_pkg;

  localparam int unsigned VRAM_ADDRESS_WIDTH = 12;
  localparam int unsigned VRAM_DATA_WIDTH    = 8;

  // CPU address of GPU VRAM offset 0; the CPU side subtracts this before pushing.
  localparam logic [15:0] VRAM_CPU_BASE = 16'h3700;

  typedef struct packed {
    logic [VRAM_ADDRESS_WIDTH-1:0] address;
    logic [VRAM_DATA_WIDTH-1:0]    data;
  } vram_write_t;

endpackage

// File: rtl/vram_write_fifo_m.sv
// DEPTH-entry FIFO of VRAM writes with an exact occupancy counter and an
// in-place overwrite port for the most recently pushed entry.
module vram_write_fifo_m
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  vram_write_t                  push_entry_i,
  input  logic                         pop_i,
  input  logic                         overwrite_i,
  input  logic [VRAM_DATA_WIDTH-1:0]   overwrite_data_i,
  output vram_write_t                  head_o,
  output vram_write_t                  tail_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH+1);

  vram_write_t       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   tail_ptr;
  logic [CountW-1:0] count_q, count_d;

  assign tail_ptr = wr_ptr_q - PtrW'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_ptr];
  assign count_o  = count_q;
  assign full_o   = (count_q == CountW'(DEPTH));
  assign empty_o  = (count_q == '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end else if (overwrite_i) begin
      mem_q[tail_ptr].data <= overwrite_data_i;
    end
  end

endmodule

// File: rtl/vram_write_queue_m.sv
// Posted-write buffer ahead of the GPU VRAM port; drains only while drain_enable.
// Optional write coalescing to the last queued address: VRAM_WRITE_QUEUE_COALESCE_EN.
module vram_write_queue_m
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = VRAM_ADDRESS_WIDTH
) (
  input  logic                        clk_12_5875,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [ADDRESS_WIDTH-1:0]    wr_address,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  input  logic                        drain_enable,
  output logic                        vram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]    vram_address,
  output logic [7:0]                  vram_data,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        empty,
  output logic                        overflow,
  input  logic                        overflow_clear
);

  localparam int unsigned CountW = $clog2(DEPTH+1);

  vram_write_t head, tail, new_entry;
  logic        fifo_full, fifo_empty;
  logic        pop, push, overwrite;
  logic        vram_write_enable_q;
  logic [ADDRESS_WIDTH-1:0] vram_address_q;
  logic [7:0]  vram_data_q;
  logic        overflow_q;

  assign new_entry = '{address: wr_address, data: wr_data};
  assign pop       = drain_enable && !fifo_empty;

`ifdef VRAM_WRITE_QUEUE_COALESCE_EN
  logic match;
  // Tail is only mergeable if it stays queued past this edge.
  assign match = !fifo_empty && !(pop && count == CountW'(1)) &&
                 (tail.address == wr_address);
  assign wr_ready  = !fifo_full || match;
  assign overwrite = wr_valid && match;
  assign push      = wr_valid && wr_ready && !match;
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign wr_ready    = !fifo_full;
  assign overwrite   = 1'b0;
  assign push        = wr_valid && wr_ready;
`endif

  vram_write_fifo_m #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i            (clk_12_5875),
    .rst_i            (rst),
    .push_i           (push),
    .push_entry_i     (new_entry),
    .pop_i            (pop),
    .overwrite_i      (overwrite),
    .overwrite_data_i (wr_data),
    .head_o           (head),
    .tail_o           (tail),
    .count_o          (count),
    .full_o           (fifo_full),
    .empty_o          (fifo_empty)
  );

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      vram_write_enable_q <= 1'b0;
      vram_address_q      <= '0;
      vram_data_q         <= '0;
    end else begin
      vram_write_enable_q <= pop;
      if (pop) begin
        vram_address_q <= head.address;
        vram_data_q    <= head.data;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overflow_q <= 1'b1;
    end else if (overflow_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign vram_write_enable = vram_write_enable_q;
  assign vram_address      = vram_address_q;
  assign vram_data         = vram_data_q;
  assign overflow          = overflow_q;
  assign empty             = fifo_empty;

endmodule

// File: tb/tb_vram_write_queue_m.sv
// Directed self-checking bench for vram_write_queue_m (DEPTH=16).
module tb_vram_write_queue_m;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 12;
  localparam int unsigned CountW = $clog2(DEPTH+1);

  logic              clk_12_5875 = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [AW-1:0]     wr_address;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              drain_enable;
  logic              vram_write_enable;
  logic [AW-1:0]     vram_address;
  logic [7:0]        vram_data;
  logic [CountW-1:0] count;
  logic              empty;
  logic              overflow;
  logic              overflow_clear;

  int checks   = 0;
  int failures = 0;

  vram_write_queue_m #(
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk_12_5875       (clk_12_5875),
    .rst               (rst),
    .wr_valid          (wr_valid),
    .wr_address        (wr_address),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .drain_enable      (drain_enable),
    .vram_write_enable (vram_write_enable),
    .vram_address      (vram_address),
    .vram_data         (vram_data),
    .count             (count),
    .empty             (empty),
    .overflow          (overflow),
    .overflow_clear    (overflow_clear)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_12_5875);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [7:0] d);
    wr_valid   = 1'b1;
    wr_address = a;
    wr_data    = d;
    tick();
    wr_valid   = 1'b0;
  endtask

  int pulses;
  int exp_idx;
  int remaining;
  logic on;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_address = '0; wr_data = '0;
    drain_enable = 1'b0; overflow_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_we", vram_write_enable, 0);
    check_eq("rst_addr", vram_address, 0);
    check_eq("rst_data", vram_data, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_ready", wr_ready, 1);

    // Three writes held, then drained in order
    write(12'h000, 8'h11);
    write(12'h001, 8'h22);
    write(12'h7FF, 8'h33);
    check_eq("t1_count", count, 3);
    check_eq("t1_no_we", vram_write_enable, 0);
    drain_enable = 1'b1;
    tick();
    check_eq("t1_p0_we", vram_write_enable, 1);
    check_eq("t1_p0", {vram_address, vram_data}, {12'h000, 8'h11});
    tick();
    check_eq("t1_p1_we", vram_write_enable, 1);
    check_eq("t1_p1", {vram_address, vram_data}, {12'h001, 8'h22});
    tick();
    check_eq("t1_p2_we", vram_write_enable, 1);
    check_eq("t1_p2", {vram_address, vram_data}, {12'h7FF, 8'h33});
    check_eq("t1_count0", count, 0);
    check_eq("t1_empty", empty, 1);
    tick();
    check_eq("t1_done_we", vram_write_enable, 0);
    check_eq("t1_hold", {vram_address, vram_data}, {12'h7FF, 8'h33});
    drain_enable = 1'b0;

    // Fill to DEPTH, drop the 17th, drain exactly 16
    for (int i = 0; i < 16; i++) write(AW'(i), 8'(8'h80 + i));
    check_eq("t2_full_ready", wr_ready, 0);
    check_eq("t2_full_count", count, 16);
    write(12'h0AA, 8'hEE);
    check_eq("t2_ovf", overflow, 1);
    check_eq("t2_count_kept", count, 16);
    drain_enable = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (vram_write_enable) begin
        check_eq($sformatf("t2_pulse%0d", pulses), {vram_address, vram_data},
                 {AW'(pulses), 8'(8'h80 + pulses)});
        pulses++;
      end
    end
    check_eq("t2_pulses", pulses, 16);
    check_eq("t2_empty", empty, 1);
    drain_enable = 1'b0;
    check_eq("t2_ovf_sticky", overflow, 1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check_eq("t2_ovf_clr", overflow, 0);

    // Streaming: one write per cycle with drain held high
    drain_enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_valid = 1'b1; wr_address = AW'(12'h100 + k); wr_data = 8'(k);
      tick();
      check_eq($sformatf("t3_count%0d", k), count <= 1, 1);
      if (k == 0) begin
        check_eq("t3_first_we", vram_write_enable, 0);
      end else begin
        check_eq($sformatf("t3_we%0d", k), vram_write_enable, 1);
        check_eq($sformatf("t3_pulse%0d", k - 1), {vram_address, vram_data},
                 {AW'(12'h100 + k - 1), 8'(k - 1)});
      end
    end
    wr_valid = 1'b0;
    tick();
    check_eq("t3_last", {vram_write_enable, vram_address, vram_data}, {1'b1, 12'h127, 8'd39});
    tick();
    check_eq("t3_idle", vram_write_enable, 0);
    drain_enable = 1'b0;

    // Gated drain: 2 cycles on, 3 off
    for (int i = 0; i < 10; i++) write(AW'(12'h200 + i), 8'(8'h40 + i));
    exp_idx = 0;
    remaining = 10;
    for (int c = 0; c < 25; c++) begin
      on = ((c % 5) < 2);
      drain_enable = on;
      tick();
      if (on && remaining > 0) begin
        check_eq($sformatf("t4_we%0d", c), vram_write_enable, 1);
        check_eq($sformatf("t4_pulse%0d", c), {vram_address, vram_data},
                 {AW'(12'h200 + exp_idx), 8'(8'h40 + exp_idx)});
        exp_idx++;
        remaining--;
      end else begin
        check_eq($sformatf("t4_idle%0d", c), vram_write_enable, 0);
      end
    end
    check_eq("t4_count", count, 0);
    drain_enable = 1'b0;

    // Reset mid-drain with entries queued and overflow set
    for (int i = 0; i < 17; i++) write(AW'(12'h300 + i), 8'(i));
    check_eq("t5_ovf", overflow, 1);
    drain_enable = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_eq("t5_count5", count, 5);
    check_eq("t5_we_pre", vram_write_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain_enable = 1'b0;
    check_eq("t5_count", count, 0);
    check_eq("t5_we", vram_write_enable, 0);
    check_eq("t5_addr", vram_address, 0);
    check_eq("t5_ovf_clr", overflow, 0);
    check_eq("t5_empty", empty, 1);

    // Same-address back-to-back writes
    write(12'h100, 8'hAA);
    write(12'h100, 8'hBB);
`ifdef VRAM_WRITE_QUEUE_COALESCE_EN
    check_eq("t6_count", count, 1);
    drain_enable = 1'b1;
    tick();
    check_eq("t6_p0", {vram_write_enable, vram_address, vram_data}, {1'b1, 12'h100, 8'hBB});
    tick();
    check_eq("t6_p1_none", vram_write_enable, 0);
`else
    check_eq("t6_count", count, 2);
    drain_enable = 1'b1;
    tick();
    check_eq("t6_p0", {vram_write_enable, vram_address, vram_data}, {1'b1, 12'h100, 8'hAA});
    tick();
    check_eq("t6_p1", {vram_write_enable, vram_address, vram_data}, {1'b1, 12'h100, 8'hBB});
    tick();
    check_eq("t6_p2_none", vram_write_enable, 0);
`endif
    drain_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
